l2_mem_burst_arbiter: RTL

//  Sits between the L2 cache controller and the main-memory port and shares the port between two requesters.
//  The requesters are the line-fill path (burst read) and the write-back/eviction path (burst write).

---
 rtl/l2_mem_burst_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/l2_mem_burst_arbiter.sv
// Round-robin arbiter that shares the main-memory port between the L2 line-fill (burst read)
// and write-back (burst write) paths. It runs one burst at a time and keeps saturating burst counts.
module l2_mem_burst_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fill_req,
  input  logic [ADDR_WIDTH-1:0]           fill_addr,
  output logic                            fill_gnt,
  output logic [DATA_WIDTH-1:0]           fill_rdata,
  output logic                            fill_rvalid,
  output logic                            fill_done,
  input  logic                            wb_req,
  input  logic [ADDR_WIDTH-1:0]           wb_addr,
  input  logic [DATA_WIDTH-1:0]           wb_wdata,
  output logic                            wb_gnt,
  output logic                            wb_wready,
  output logic                            wb_done,
  output logic                            mem_cmd_valid,
  output logic                            mem_cmd_we,
  output logic [ADDR_WIDTH-1:0]           mem_cmd_addr,
  input  logic                            mem_cmd_ready,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_rvalid,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic                            mem_wvalid,
  input  logic                            mem_wready,
  output logic [$clog2(BURST_LENGTH)-1:0] beat_idx,
  output logic                            busy,
  output logic [CNT_WIDTH-1:0]            fill_count,
  output logic [CNT_WIDTH-1:0]            wb_count
);

  localparam int BW       = $clog2(BURST_LENGTH);
  localparam int LINE_LSB = $clog2(BURST_LENGTH * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_LSB;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_READ, S_WRITE, S_DONE} state_t;

  state_t                state, state_nxt;
  logic                  last_wb;
  logic                  grant_any, grant_wb;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [BW-1:0]         beat;
  logic                  rd_hs, wr_hs, last_beat;

  // A tie goes to whichever requester was not served last; last_wb=0 means FILL.
  assign grant_any = fill_req | wb_req;
  assign grant_wb  = wb_req & (~fill_req | ~last_wb);
  assign rd_hs     = (state == S_READ)  & mem_rvalid;
  assign wr_hs     = (state == S_WRITE) & mem_wready;
  assign last_beat = (beat == BW'(BURST_LENGTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (grant_any) state_nxt = S_CMD;
      S_CMD:   if (mem_cmd_ready) state_nxt = cmd_we ? S_WRITE : S_READ;
      S_READ:  if (rd_hs && last_beat) state_nxt = S_DONE;
      S_WRITE: if (wr_hs && last_beat) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wb    <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      beat       <= '0;
      fill_gnt   <= 1'b0;
      wb_gnt     <= 1'b0;
      fill_count <= '0;
      wb_count   <= '0;
    end else begin
      fill_gnt <= 1'b0;
      wb_gnt   <= 1'b0;
      if (state == S_IDLE && grant_any) begin
        fill_gnt <= ~grant_wb;
        wb_gnt   <= grant_wb;
        last_wb  <= grant_wb;
        cmd_we   <= grant_wb;
        cmd_addr <= (grant_wb ? wb_addr : fill_addr) & LINE_MASK;
      end
      if (state == S_CMD && mem_cmd_ready) beat <= '0;
      else if (rd_hs || wr_hs)             beat <= beat + BW'(1);
      if (state == S_DONE) begin
        if (cmd_we) begin
          if (wb_count != '1) wb_count <= wb_count + CNT_WIDTH'(1);
        end else begin
          if (fill_count != '1) fill_count <= fill_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    mem_cmd_valid = (state == S_CMD);
    mem_cmd_we    = cmd_we;
    mem_cmd_addr  = cmd_addr;
    fill_rvalid   = rd_hs;
    fill_rdata    = (state == S_READ) ? mem_rdata : '0;
    mem_wvalid    = (state == S_WRITE);
    mem_wdata     = (state == S_WRITE) ? wb_wdata : '0;
    wb_wready     = wr_hs;
    fill_done     = (state == S_DONE) & ~cmd_we;
    wb_done       = (state == S_DONE) & cmd_we;
    busy          = (state != S_IDLE);
    beat_idx      = beat;
  end

endmodule
